// File: rtl/biriscv_div_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM state encoding and
// the rd field extractor used for hazard tracking.
package biriscv_div_arbiter_pkg;

  typedef enum logic [1:0] {
    DIVARB_IDLE  = 2'd0,
    DIVARB_BUSY  = 2'd1,
    DIVARB_DRAIN = 2'd2,
    DIVARB_DONE  = 2'd3
  } divarb_state_e;

  localparam int RD_IDX_MSB = 11;
  localparam int RD_IDX_LSB = 7;

  function automatic logic [4:0] rd_idx_r(input logic [31:0] opcode);
    return opcode[RD_IDX_MSB:RD_IDX_LSB];
  endfunction

endpackage

// File: rtl/biriscv_div_arbiter.sv
// Arbitrates the single out-of-pipe divider between the two issue lanes,
// tracks the pending rd and returns a lane-tagged result; drains on squash.
module biriscv_div_arbiter
  import biriscv_div_arbiter_pkg::*;
#(
  parameter int RESULT_HOLD = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [31:0] opcode0_i,
  input  logic [31:0] opcode1_i,
  input  logic [31:0] ra0_i,
  input  logic [31:0] rb0_i,
  input  logic [31:0] ra1_i,
  input  logic [31:0] rb1_i,
  input  logic        squash_i,
  output logic        stall0_o,
  output logic        stall1_o,
  output logic        div_valid_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_ra_o,
  output logic [31:0] div_rb_o,
  input  logic        div_complete_i,
  input  logic [31:0] div_result_i,
  output logic        pending_valid_o,
  output logic [4:0]  pending_rd_o,
  output logic        result_valid_o,
  output logic        result_lane_o,
  output logic [4:0]  result_rd_o,
  output logic [31:0] result_o,
  input  logic        result_accept_i
);

  divarb_state_e state_q, state_d;

  logic        div_valid_q,    div_valid_d;
  logic [31:0] div_opcode_q,   div_opcode_d;
  logic [31:0] div_ra_q,       div_ra_d;
  logic [31:0] div_rb_q,       div_rb_d;
  logic        lane_q,         lane_d;
  logic [4:0]  rd_q,           rd_d;
  logic        result_valid_q, result_valid_d;
  logic        result_lane_q,  result_lane_d;
  logic [4:0]  result_rd_q,    result_rd_d;
  logic [31:0] result_q,       result_d;

  // Lane 0 is older, so it always wins the IDLE grant.
  logic [31:0] sel_opcode;
  logic [31:0] sel_ra;
  logic [31:0] sel_rb;

  assign sel_opcode = req0_i ? opcode0_i : opcode1_i;
  assign sel_ra     = req0_i ? ra0_i     : ra1_i;
  assign sel_rb     = req0_i ? rb0_i     : rb1_i;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    div_valid_d    = 1'b0;
    div_opcode_d   = div_opcode_q;
    div_ra_d       = div_ra_q;
    div_rb_d       = div_rb_q;
    lane_d         = lane_q;
    rd_d           = rd_q;
    result_valid_d = 1'b0;
    result_lane_d  = result_lane_q;
    result_rd_d    = result_rd_q;
    result_d       = result_q;

    unique case (state_q)
      DIVARB_IDLE: begin
        if ((req0_i || req1_i) && !squash_i) begin
          state_d      = DIVARB_BUSY;
          div_valid_d  = 1'b1;
          div_opcode_d = sel_opcode;
          div_ra_d     = sel_ra;
          div_rb_d     = sel_rb;
          lane_d       = ~req0_i;
          rd_d         = rd_idx_r(sel_opcode);
        end
      end
      DIVARB_BUSY: begin
        if (div_complete_i && squash_i) begin
          state_d = DIVARB_IDLE;
        end else if (div_complete_i) begin
          result_d       = div_result_i;
          result_lane_d  = lane_q;
          result_rd_d    = rd_q;
          result_valid_d = 1'b1;
          state_d        = (RESULT_HOLD != 0) ? DIVARB_DONE : DIVARB_IDLE;
        end else if (squash_i) begin
          // The divider cannot be aborted; wait out its completion.
          state_d = DIVARB_DRAIN;
        end
      end
      DIVARB_DRAIN: begin
        if (div_complete_i) state_d = DIVARB_IDLE;
      end
      DIVARB_DONE: begin
        // Squash wins over accept: the result is dropped either way.
        if (result_accept_i || squash_i) state_d = DIVARB_IDLE;
        else result_valid_d = 1'b1;
      end
      default: state_d = DIVARB_IDLE;
    endcase
  end

  // NOTE: payload and result registers are reset too, so every output reads 0 straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= DIVARB_IDLE;
      div_valid_q    <= 1'b0;
      div_opcode_q   <= '0;
      div_ra_q       <= '0;
      div_rb_q       <= '0;
      lane_q         <= 1'b0;
      rd_q           <= '0;
      result_valid_q <= 1'b0;
      result_lane_q  <= 1'b0;
      result_rd_q    <= '0;
      result_q       <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q        <= state_d;
      div_valid_q    <= div_valid_d;
      div_opcode_q   <= div_opcode_d;
      div_ra_q       <= div_ra_d;
      div_rb_q       <= div_rb_d;
      lane_q         <= lane_d;
      rd_q           <= rd_d;
      result_valid_q <= result_valid_d;
      result_lane_q  <= result_lane_d;
      result_rd_q    <= result_rd_d;
      result_q       <= result_d;
    end
  end

  assign stall0_o = req0_i & (state_q != DIVARB_IDLE);
  assign stall1_o = req1_i & ((state_q != DIVARB_IDLE) | req0_i);

  assign div_valid_o  = div_valid_q;
  assign div_opcode_o = div_opcode_q;
  assign div_ra_o     = div_ra_q;
  assign div_rb_o     = div_rb_q;

  // A squashed divide in DRAIN must not create a hazard.
  assign pending_valid_o = (state_q == DIVARB_BUSY) || (state_q == DIVARB_DONE);
  assign pending_rd_o    = pending_valid_o ? rd_q : 5'd0;

  assign result_valid_o = result_valid_q;
  assign result_lane_o  = result_lane_q;
  assign result_rd_o    = result_rd_q;
  assign result_o       = result_q;

endmodule

// File: doc/biriscv_div_arbiter.md
# biriscv_div_arbiter

Shares the single out-of-pipe divider between the two issue lanes of the dual-issue core. It sits between issue and the two pipeline-control instances. It grants the divider to one lane at a time, with the older lane 0 first. It launches the operation, tracks the pending destination register for hazard checks, and returns the result tagged with its lane. It survives pipeline squashes by draining in-flight divides.

## Interface
Parameters:
- RESULT_HOLD, default 1: 1 = result held until `result_accept_i`; 0 = `result_valid_o` is a one-cycle pulse, no accept required.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req0_i`, `req1_i` in 1 each: lane issues a divide/remainder this cycle (valid & accepted).
- `opcode0_i`, `opcode1_i` in 32 each: instruction word; rd = [11:7].
- `ra0_i`, `rb0_i`, `ra1_i`, `rb1_i` in 32 each: operands.
- `squash_i` in 1: pipeline flush; kills any outstanding divide.
- `stall0_o`, `stall1_o` out 1 each: lane must hold its divide request.
- `div_valid_o` out 1: launch pulse to divider.
- `div_opcode_o`, `div_ra_o`, `div_rb_o` out 32 each: registered launch payload.
- `div_complete_i` in 1: divider finished.
- `div_result_i` in 32: divider result, valid with `div_complete_i`.
- `pending_valid_o` out 1: a live divide owns `pending_rd_o`.
- `pending_rd_o` out 5: destination of the live divide (0 when not valid).
- `result_valid_o` out 1: result available.
- `result_lane_o` out 1: owning lane.
- `result_rd_o` out 5: destination register.
- `result_o` out 32: quotient/remainder.
- `result_accept_i` in 1: writeback consumed the result (RESULT_HOLD=1).

## Operation
- States: IDLE, BUSY, DRAIN, DONE; 2-bit encoding.
- IDLE: the grant is combinational.
  - Lane 0 wins if `req0_i`, else lane 1.
  - No grant if `squash_i`.
  - On grant: latch opcode/ra/rb/lane/rd, go to BUSY, and pulse `div_valid_o` the next cycle.
- BUSY, on `div_complete_i`:
  - Capture result.
  - Go to DONE if RESULT_HOLD=1; otherwise pulse `result_valid_o` for one cycle and go to IDLE.
- BUSY with `squash_i` (no complete): go to DRAIN. The divider cannot be aborted.
- BUSY with `squash_i` and `div_complete_i` in the same cycle: discard the result, go to IDLE.
- DRAIN: wait for `div_complete_i`, discard it, go to IDLE. `squash_i` is ignored here.
- DONE:
  - `result_accept_i` takes the machine to IDLE.
  - `squash_i` takes it to IDLE and drops the result.
  - If both are asserted, accept has no effect: the result is dropped.
- Stalls:
  - `stall0_o` = `req0_i` & (state != IDLE).
  - `stall1_o` = `req1_i` & ((state != IDLE) | `req0_i`).
  - When both lanes request in IDLE, lane 1 stalls and is granted after lane 0's result leaves.
- `pending_valid_o` = state ∈ {BUSY, DONE}. It is 0 in DRAIN, because a squashed rd must not create a hazard.
- `div_complete_i` in IDLE or DONE is a protocol error: ignore it, no state change.

## Timing
- Reset values:
  - state IDLE.
  - All outputs 0: stalls, `div_valid_o`, payload, pending, result, `result_lane_o`.
- Request to `div_valid_o`: 1 cycle, registered.
- `div_complete_i` to `result_valid_o`: 1 cycle, with `result_o` registered.
- Back-to-back divides: the accept cycle moves the machine to IDLE. The next grant happens the cycle after accept, so there is a minimum 1-cycle gap.
- Reset mid-operation returns to IDLE immediately. The divider is reset by the same `rst_i`.
- `result_o`, `result_rd_o` and `result_lane_o` hold stable while `result_valid_o`=1.

## Structure
- State encoding `DIVARB_IDLE/BUSY/DRAIN/DONE` goes in the shared `biriscv_defs.v`.
- Reuse the existing rd field macro `RD_IDX_R` for rd extraction.
- Single flat module; no sub-module needed. The lane-select payload mux is a few lines.

## Test plan
- Lane 0 DIV, ra=100, rb=7; divider completes 5 cycles after launch -> `div_valid_o` 1 cycle after req; `result_valid_o`=1, `result_o`=14, `result_lane_o`=0 one cycle after complete; IDLE after accept.
- `req0_i` and `req1_i` in the same cycle, rd 5 and 6 -> lane 0 granted, `stall1_o`=1 until lane 0 accept+1; second result `result_lane_o`=1, `result_rd_o`=6.
- `squash_i` 2 cycles into BUSY -> DRAIN, `pending_valid_o`=0; the next `div_complete_i` produces no `result_valid_o`; a new `req1_i` stalls until IDLE.
- `squash_i` and `div_complete_i` in the same cycle in BUSY -> IDLE next cycle, no result.
- RESULT_HOLD=1 with accept withheld 10 cycles -> result stable, `pending_rd_o` held, `stall0_o`=1 on a new request; RESULT_HOLD=0 -> one-cycle `result_valid_o` pulse.
- Assert `rst_i` while in BUSY -> all outputs 0 asynchronously; IDLE after release.
